chip_config_loader: RTL and testbench

Frame controller that sits directly upstream of the chip-side bit serializer. It holds a host-written shadow copy of the per-node chip configuration and, on a start request, freezes it onto the parallel `array_to_chip` bus. It then generates exactly `BIT_CHIP*NODE` shift-clock pulses on `clk_data` so the serializer emits one full frame, and closes the frame with a latch strobe to the chip and a `done` pulse. Everything runs in the `clk_main` domain.

---
 rtl/chip_config_loader.sv | 142 ++++++++++++++
 tb/tb_chip_config_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_config_loader.sv
// Frame controller ahead of the chip bit serializer: freezes a host-written shadow configuration and clocks it out as one frame.
// Optional macro CFG_LOADER_READBACK_EN adds a combinational shadow readback port (rd_node/rd_data).
module chip_config_loader #(
  parameter int BIT_CHIP = 6,
  parameter int NODE     = 16,
  parameter int DIV_HALF = 4,
  parameter int LOAD_LEN = 2
) (
  input  logic                        clk_main,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [$clog2(NODE)-1:0]     wr_node,
  input  logic [BIT_CHIP-1:0]         wr_data,
  input  logic                        start,
  output logic [BIT_CHIP*NODE-1:0]    array_to_chip,
  output logic                        clk_data,
  output logic                        load_chip,
  output logic                        busy,
  output logic                        done
`ifdef CFG_LOADER_READBACK_EN
  ,
  input  logic [$clog2(NODE)-1:0]     rd_node,
  output logic [BIT_CHIP-1:0]         rd_data
`endif
);

  localparam int N  = BIT_CHIP * NODE;
  localparam int EW = $clog2(N + 1);
  localparam int HW = $clog2(DIV_HALF);
  localparam int LW = $clog2(LOAD_LEN + 1);

  localparam logic [EW-1:0] EDGE_MAX = EW'(N);
  localparam logic [HW-1:0] HALF_MAX = HW'(DIV_HALF - 1);
  localparam logic [LW-1:0] LOAD_MAX = LW'(LOAD_LEN - 1);

  typedef enum logic [2:0] {IDLE, LO, HI, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     half_cnt, half_cnt_nxt;
  logic [EW-1:0]     edge_cnt, edge_cnt_nxt;
  logic [LW-1:0]     load_cnt, load_cnt_nxt;
  logic              capture;

  logic [BIT_CHIP-1:0] shadow_mem [NODE];
  logic [N-1:0]        shadow_flat;

  // Shadow words are kept in host bit order; writes to nonexistent nodes are dropped.
  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < NODE; k++) shadow_mem[k] <= '0;
    end else if (wr_en && (32'(wr_node) < NODE)) begin
      shadow_mem[wr_node] <= wr_data;
    end
  end

  // Node 0's MSB maps to frame index 0 so it is serialized first.
  for (genvar k = 0; k < NODE; k++) begin : g_node
    for (genvar b = 0; b < BIT_CHIP; b++) begin : g_bit
      assign shadow_flat[k*BIT_CHIP + BIT_CHIP-1-b] = shadow_mem[k][b];
    end
  end

`ifdef CFG_LOADER_READBACK_EN
  always_comb begin
    rd_data = '0;
    if (32'(rd_node) < NODE) rd_data = shadow_mem[rd_node];
  end
`endif

  always_comb begin
    state_nxt    = state;
    half_cnt_nxt = half_cnt;
    edge_cnt_nxt = edge_cnt;
    load_cnt_nxt = load_cnt;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture      = 1'b1;
          state_nxt    = LO;
          half_cnt_nxt = '0;
          edge_cnt_nxt = '0;
        end
      end
      LO: begin
        if (half_cnt == HALF_MAX) begin
          half_cnt_nxt = '0;
          // A trailing low phase follows the last fall before the latch strobe.
          if (edge_cnt < EDGE_MAX) begin
            state_nxt    = HI;
            edge_cnt_nxt = edge_cnt + EW'(1);
          end else begin
            state_nxt    = LOAD;
            load_cnt_nxt = '0;
          end
        end else begin
          half_cnt_nxt = half_cnt + HW'(1);
        end
      end
      HI: begin
        if (half_cnt == HALF_MAX) begin
          half_cnt_nxt = '0;
          state_nxt    = LO;
        end else begin
          half_cnt_nxt = half_cnt + HW'(1);
        end
      end
      LOAD: begin
        if (load_cnt == LOAD_MAX) state_nxt = DONE;
        else load_cnt_nxt = load_cnt + LW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      half_cnt      <= '0;
      edge_cnt      <= '0;
      load_cnt      <= '0;
      array_to_chip <= '0;
      clk_data      <= 1'b0;
      load_chip     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state     <= state_nxt;
      half_cnt  <= half_cnt_nxt;
      edge_cnt  <= edge_cnt_nxt;
      load_cnt  <= load_cnt_nxt;
      if (capture) array_to_chip <= shadow_flat;
      clk_data  <= (state_nxt == HI);
      load_chip <= (state_nxt == LOAD);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_chip_config_loader.sv
// Self-checking bench for chip_config_loader: table-driven frames on the default build, random frames on a small build.
// Exercises the readback port when CFG_LOADER_READBACK_EN is defined.
module tb_chip_config_loader;

  localparam int BC = 6, ND = 16, DH = 4, LL = 2, NB = BC*ND;
  localparam int SBC = 3, SND = 5, SDH = 2, SLL = 1, SNB = SBC*SND;

  logic clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  logic clr = 1'b1;
  logic wr_en = 1'b0, start = 1'b0;
  logic [3:0] wr_node = '0;
  logic [5:0] wr_data = '0;
  logic [NB-1:0] array_to_chip;
  logic clk_data, load_chip, busy, done;

  logic s_wr_en = 1'b0, s_start = 1'b0;
  logic [2:0] s_wr_node = '0;
  logic [2:0] s_wr_data = '0;
  logic [SNB-1:0] s_array;
  logic s_clk_data, s_load_chip, s_busy, s_done;

`ifdef CFG_LOADER_READBACK_EN
  logic [3:0] rd_node = '0;
  logic [5:0] rd_data;
  logic [2:0] s_rd_node = '0;
  logic [2:0] s_rd_data;
`endif

  chip_config_loader #(.BIT_CHIP(BC), .NODE(ND), .DIV_HALF(DH), .LOAD_LEN(LL)) dut (
    .clk_main(clk_main), .clr(clr), .wr_en(wr_en), .wr_node(wr_node), .wr_data(wr_data),
    .start(start), .array_to_chip(array_to_chip), .clk_data(clk_data), .load_chip(load_chip),
    .busy(busy), .done(done)
`ifdef CFG_LOADER_READBACK_EN
    , .rd_node(rd_node), .rd_data(rd_data)
`endif
  );

  chip_config_loader #(.BIT_CHIP(SBC), .NODE(SND), .DIV_HALF(SDH), .LOAD_LEN(SLL)) dut_s (
    .clk_main(clk_main), .clr(clr), .wr_en(s_wr_en), .wr_node(s_wr_node), .wr_data(s_wr_data),
    .start(s_start), .array_to_chip(s_array), .clk_data(s_clk_data), .load_chip(s_load_chip),
    .busy(s_busy), .done(s_done)
`ifdef CFG_LOADER_READBACK_EN
    , .rd_node(s_rd_node), .rd_data(s_rd_data)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [NB-1:0]  model_shadow = '0;
  logic [SNB-1:0] s_model_shadow = '0;

  typedef struct {
    logic [3:0]    node;
    logic [5:0]    data;
    logic [NB-1:0] frame;
  } vec_t;
  vec_t vecs [4];

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  task automatic model_write(input int node, input logic [5:0] data);
    if (node < ND)
      for (int b = 0; b < BC; b++) model_shadow[node*BC + BC-1-b] = data[b];
  endtask

  task automatic s_model_write(input int node, input logic [2:0] data);
    if (node < SND)
      for (int b = 0; b < SBC; b++) s_model_shadow[node*SBC + SBC-1-b] = data[b];
  endtask

  task automatic applyStimulus(input logic [3:0] node, input logic [5:0] data);
    wr_en = 1'b1; wr_node = node; wr_data = data;
    step();
    wr_en = 1'b0;
    model_write(int'(node), data);
  endtask

  // Expected {clk_data, load_chip, busy, done} k cycles after the accepted start.
  function automatic logic [3:0] exp_wave(input int n, input int d, input int l, input int k);
    int p, load_k;
    logic c, ld, b, dn;
    p      = (k - 1) / d;
    load_k = 1 + (2*n + 1)*d;
    c  = (k >= 1) && (p < 2*n) && (p % 2 == 1);
    ld = (k >= load_k) && (k < load_k + l);
    dn = (k == load_k + l);
    b  = (k >= 1) && (k <= load_k + l);
    return {c, ld, b, dn};
  endfunction

  task automatic runFrame(input logic [NB-1:0] exp_frame, input int wr_k, input logic [5:0] wr_val,
                          input int start_k, input int clr_k, input string tag);
    int total, rises, wave_err, first_rise, second_rise, load_first, done_k;
    logic prev_clk;
    total = (2*NB + 1)*DH + LL + 2;
    rises = 0; wave_err = 0; first_rise = -1; second_rise = -1; load_first = -1; done_k = -1;
    prev_clk = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput({tag, " frame at t+1"}, 128'(array_to_chip), 128'(exp_frame));
    for (int k = 1; k <= total; k++) begin
      if (k == clr_k) begin
        clr = 1'b1;
        #1;
        checkOutput({tag, " outputs after clr"}, 128'({array_to_chip, clk_data, load_chip, busy, done}), '0);
        model_shadow = '0;
        step();
        clr = 1'b0;
        return;
      end
      if (({clk_data, load_chip, busy, done} !== exp_wave(NB, DH, LL, k)) || (array_to_chip !== exp_frame))
        wave_err++;
      if (clk_data && !prev_clk) begin
        rises++;
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) second_rise = k;
      end
      if (load_chip && load_first < 0) load_first = k;
      if (done && done_k < 0) done_k = k;
      prev_clk = clk_data;
      if (k == wr_k) begin
        wr_en = 1'b1; wr_node = 4'd3; wr_data = wr_val;
        model_write(3, wr_val);
      end
      if (k == start_k) start = 1'b1;
      step();
      wr_en = 1'b0;
      start = 1'b0;
    end
    checkOutput({tag, " mismatching cycles"}, 128'(wave_err), 0);
    checkOutput({tag, " rise count"}, 128'(rises), 128'(NB));
    checkOutput({tag, " first rise"}, 128'(first_rise), 128'(1 + DH));
    checkOutput({tag, " second rise"}, 128'(second_rise), 128'(1 + 3*DH));
    checkOutput({tag, " load start"}, 128'(load_first), 128'((2*NB + 1)*DH + 1));
    checkOutput({tag, " done cycle"}, 128'(done_k), 128'((2*NB + 1)*DH + LL + 1));
  endtask

  task automatic runSmallFrame(input string tag);
    int total, rises, wave_err;
    logic prev_clk;
    logic [SNB-1:0] exp_frame;
    exp_frame = s_model_shadow;
    total = (2*SNB + 1)*SDH + SLL + 2;
    rises = 0; wave_err = 0; prev_clk = 1'b0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    checkOutput({tag, " frame at t+1"}, 128'(s_array), 128'(exp_frame));
    for (int k = 1; k <= total; k++) begin
      if (({s_clk_data, s_load_chip, s_busy, s_done} !== exp_wave(SNB, SDH, SLL, k)) || (s_array !== exp_frame))
        wave_err++;
      if (s_clk_data && !prev_clk) rises++;
      prev_clk = s_clk_data;
      s_wr_en   = ($urandom_range(0, 2) == 0);
      s_wr_node = 3'($urandom_range(0, 7));
      s_wr_data = 3'($urandom);
      if (s_wr_en) s_model_write(int'(s_wr_node), s_wr_data);
      s_start = (k < total) && ($urandom_range(0, 3) == 0);
      step();
      s_wr_en = 1'b0;
      s_start = 1'b0;
    end
    checkOutput({tag, " mismatching cycles"}, 128'(wave_err), 0);
    checkOutput({tag, " rise count"}, 128'(rises), 128'(SNB));
  endtask

  initial begin
    vecs[0] = '{node: 4'd0,  data: 6'b100000, frame: 96'h1};
    vecs[1] = '{node: 4'd15, data: 6'b000001, frame: 96'h8000_0000_0000_0000_0000_0001};
    vecs[2] = '{node: 4'd3,  data: 6'h2A,     frame: 96'h8000_0000_0000_0000_0054_0001};
    vecs[3] = '{node: 4'd0,  data: 6'b000000, frame: 96'h8000_0000_0000_0000_0054_0000};

    step();
    step();
    checkOutput("reset outputs", 128'({array_to_chip, clk_data, load_chip, busy, done}), '0);
    checkOutput("reset outputs small", 128'({s_array, s_clk_data, s_load_chip, s_busy, s_done}), '0);
    clr = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].node, vecs[i].data);
      runFrame(vecs[i].frame, -1, 6'h0, -1, -1, $sformatf("vec%0d", i));
    end

    runFrame(model_shadow, 50, 6'h15, 100, -1, "midframe");
    runFrame(96'h8000_0000_0000_0000_00A8_0000, -1, 6'h0, -1, -1, "after midframe");

`ifdef CFG_LOADER_READBACK_EN
    applyStimulus(4'd5, 6'h2A);
    rd_node = 4'd5;
    #1;
    checkOutput("readback node5", 128'(rd_data), 128'(6'h2A));
    wr_en = 1'b1; wr_node = 4'd5; wr_data = 6'h11;
    #1;
    checkOutput("readback during write", 128'(rd_data), 128'(6'h2A));
    step();
    wr_en = 1'b0;
    model_write(5, 6'h11);
    checkOutput("readback after write", 128'(rd_data), 128'(6'h11));
    s_rd_node = 3'd5;
    #1;
    checkOutput("readback out of range", 128'(s_rd_data), 0);
`endif

    runFrame(model_shadow, -1, 6'h0, -1, 300, "clr");
    runFrame(model_shadow, -1, 6'h0, -1, -1, "after clr");

    s_wr_en = 1'b1; s_wr_node = 3'd6; s_wr_data = 3'b111;
    step();
    s_wr_node = 3'd5;
    step();
    s_wr_en = 1'b0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    checkOutput("out of range write ignored", 128'(s_array), 0);
    repeat (SNB*SDH*2 + 8) step();
    s_wr_en = 1'b1; s_wr_node = 3'd4; s_wr_data = 3'b001;
    step();
    s_wr_en = 1'b0;
    s_model_write(4, 3'b001);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    checkOutput("last node lsb", 128'(s_array), 128'(15'h4000));
    repeat (SNB*SDH*2 + 8) step();

    for (int f = 0; f < 8; f++) runSmallFrame($sformatf("random%0d", f));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
